// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

endpackage

// File: rtl/fetch_stage_hs_if.sv
// Fetch-stage bundle: imem ready/valid port, redirect input, IF/ID output and counters.
interface fetch_stage_hs_if #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int CNT_W = 16
);

  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [XLEN-1:0]  imem_req_addr;
  logic             imem_resp_valid;
  logic [ILEN-1:0]  imem_resp_data;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             id_ready;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [XLEN-1:0]  id_pc_plus4;
  logic [ILEN-1:0]  id_instr;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output imem_req_valid, imem_req_addr,
    output id_valid, id_pc, id_pc_plus4, id_instr,
    output fetch_cnt, drop_cnt,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  id_valid, id_pc, id_pc_plus4, id_instr,
    input  fetch_cnt, drop_cnt,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/pc_reg_en.sv
// Program counter with load enable; redirect has priority over the sequential step.
module pc_reg_en
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_step,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            w_load;

  // Redirect targets are word-aligned by clearing the two low bits.
  always_comb begin
    w_load    = i_redirect | i_step;
    w_pc_next = r_pc;
    if (i_redirect) begin
      w_pc_next = i_redirect_pc & ~XLEN'(3);
    end else if (i_step) begin
      w_pc_next = r_pc + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_load) begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage_hs.sv
// Instruction-fetch front end: single-outstanding imem request FSM, one-entry IF/ID register.
module fetch_stage_hs
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  fetch_stage_hs_if.master bus
);

  fetch_state_e     r_state;
  fetch_state_e     w_state_next;
  logic             r_id_valid;
  logic [XLEN-1:0]  r_id_pc;
  logic [ILEN-1:0]  r_id_instr;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_slot_free;
  logic             w_req_valid;
  logic             w_req_fire;
  logic             w_flush;
  logic             w_take_resp;
  logic             w_drop_resp;
  logic             w_deliver;
  logic [XLEN-1:0]  w_pc;

  pc_reg_en #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst           (reset),
    .i_redirect    (bus.redirect_valid),
    .i_redirect_pc (bus.redirect_pc),
    .i_step        (w_take_resp),
    .o_pc          (w_pc)
  );

  // A request may only go out when the IF/ID slot is empty or draining this cycle,
  // so the slot is guaranteed free when the response lands.
  assign w_slot_free = !r_id_valid | bus.id_ready;
  assign w_req_valid = (r_state == REQ) & w_slot_free & !bus.redirect_valid & !reset;
  assign w_req_fire  = w_req_valid & bus.imem_req_ready;
  assign w_flush     = bus.redirect_valid & (r_state != IDLE);
  assign w_take_resp = (r_state == WAIT) & bus.imem_resp_valid & !bus.redirect_valid;
  assign w_drop_resp = bus.imem_resp_valid &
                       ((r_state == DROP) | ((r_state == WAIT) & bus.redirect_valid));
  assign w_deliver   = r_id_valid & bus.id_ready;

  // A response arriving with a redirect retires the outstanding request, so go straight to REQ.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: w_state_next = REQ;
      REQ:  if (w_req_fire) w_state_next = WAIT;
      WAIT: begin
        if (bus.imem_resp_valid)     w_state_next = REQ;
        else if (bus.redirect_valid) w_state_next = DROP;
      end
      DROP: if (bus.imem_resp_valid) w_state_next = REQ;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_id_valid  <= 1'b0;
      r_id_pc     <= '0;
      r_id_instr  <= ILEN'(NOP_INSTR);
      r_fetch_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_flush) begin
        r_id_valid <= 1'b0;
      end else if (w_take_resp) begin
        r_id_valid <= 1'b1;
      end else if (bus.id_ready) begin
        r_id_valid <= 1'b0;
      end
      if (w_take_resp) begin
        r_id_instr <= bus.imem_resp_data;
        r_id_pc    <= w_pc;
      end
      if (w_deliver) begin
        r_fetch_cnt <= r_fetch_cnt + 1'b1;
      end
      if (w_drop_resp) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = w_pc;
  assign bus.id_valid       = r_id_valid;
  assign bus.id_pc          = r_id_pc;
  assign bus.id_pc_plus4    = r_id_pc + XLEN'(PC_STEP);
  assign bus.id_instr       = r_id_instr;
  assign bus.fetch_cnt      = r_fetch_cnt;
  assign bus.drop_cnt       = r_drop_cnt;

endmodule
